// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
// Contents: round state encoding, datapath widths and the default timing
// constants used as parameter defaults by whack_game_ctrl.
package whack_pkg;

    // Round state; the encoding is visible on the o_state port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_OVER      = 2'd3
    } state_t;

    localparam int SCORE_W = 24;
    localparam int TIME_W  = 8;
    localparam int LEVEL_W = 3;

    localparam int DEF_SEC_CYCLES     = 50_000_000;
    localparam int DEF_COUNTDOWN_SECS = 3;
    localparam int DEF_ROUND_SECS     = 60;
    localparam int DEF_BASE_PERIOD    = 200_000_000;
    localparam int DEF_LEVEL_SHIFT    = 4;
    localparam int DEF_MAX_LEVEL      = 3;

endpackage

// File: rtl/whack_tick_div.sv
// tick_div: free-running modulo-DIV counter that emits a one-cycle tick.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset, clears the count
//   i_clr  - synchronous clear, same effect as reset
//   i_en   - count enable; the count holds while low
//   o_tick - high in the cycle the count sits at DIV-1 (while enabled);
//            the count wraps to 0 on the following edge
module tick_div #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: round sequencer above the mole/scoring block.
// Runs IDLE -> COUNTDOWN -> PLAY -> OVER, drives the mole block's reset and
// pattern-load strobe, tracks the per-round score against a base snapshot of
// the never-resetting cumulative score, and keeps a high score.
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_start          - start button (synchronised); rising edge starts a round
//   i_score          - cumulative score from the mole block
//   o_mole_rst       - mole block reset, high whenever not in PLAY
//   o_mole_load      - one-cycle strobe to load a new mole pattern
//   o_state          - current state (IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3)
//   o_time_left      - seconds remaining in COUNTDOWN/PLAY, 0 otherwise
//   o_level          - speed level, min(MAX_LEVEL, round_score >> LEVEL_SHIFT)
//   o_round_score    - score earned in the current or last round
//   o_high_score     - best round score since reset
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int SEC_CYCLES     = DEF_SEC_CYCLES,
    parameter int COUNTDOWN_SECS = DEF_COUNTDOWN_SECS,
    parameter int ROUND_SECS     = DEF_ROUND_SECS,
    parameter int BASE_PERIOD    = DEF_BASE_PERIOD,
    parameter int LEVEL_SHIFT    = DEF_LEVEL_SHIFT,
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_mole_rst,
    output logic               o_mole_load,
    output logic [1:0]         o_state,
    output logic [TIME_W-1:0]  o_time_left,
    output logic [LEVEL_W-1:0] o_level,
    output logic [SCORE_W-1:0] o_round_score,
    output logic [SCORE_W-1:0] o_high_score
);

    localparam int PER_W = $clog2(BASE_PERIOD) + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_start_prev;
    logic               w_start_edge;
    logic               w_sec_tick;
    logic               w_last_sec;
    logic               w_state_change;
    logic [TIME_W-1:0]  r_time_left;
    logic [SCORE_W-1:0] r_base;
    logic [SCORE_W-1:0] r_round_score;
    logic [SCORE_W-1:0] r_high_score;
    logic [LEVEL_W-1:0] r_level;
    logic               r_mole_load;
    logic [PER_W-1:0]   r_per_cnt;
    logic [PER_W-1:0]   w_per_lim;
    logic               w_per_wrap;
    logic [SCORE_W-1:0] w_round_next;
    logic [SCORE_W-1:0] w_level_raw;
    logic [LEVEL_W-1:0] w_level_next;

    // Previous-sample register resets to 1 so a button held through reset
    // does not look like a fresh press.
    assign w_start_edge   = i_start && !r_start_prev;
    assign w_last_sec     = w_sec_tick && (r_time_left == TIME_W'(1));
    assign w_state_change = (w_next_state != r_state);

    // Second divider: runs only in the timed states, restarts on every entry.
    tick_div #(
        .DIV (SEC_CYCLES)
    ) u_sec_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_state_change),
        .i_en   ((r_state == ST_COUNTDOWN) || (r_state == ST_PLAY)),
        .o_tick (w_sec_tick)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_start_prev <= i_start;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_start_edge) w_next_state = ST_COUNTDOWN;
            ST_COUNTDOWN: if (w_last_sec)   w_next_state = ST_PLAY;
            ST_PLAY:      if (w_last_sec)   w_next_state = ST_OVER;
            ST_OVER:      if (w_start_edge) w_next_state = ST_COUNTDOWN;
            default:                        w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_state    = r_state;
        o_mole_rst = (r_state != ST_PLAY);
    end

    // Score earned since PLAY entry; a cumulative score that falls below the
    // snapshot counts as nothing rather than wrapping.
    assign w_round_next = (i_score >= r_base) ? (i_score - r_base) : '0;
    assign w_level_raw  = w_round_next >> LEVEL_SHIFT;
    assign w_level_next = (w_level_raw > SCORE_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                              : w_level_raw[LEVEL_W-1:0];

    // Refresh period halves per level. The >= compare makes a counter that
    // is already past a freshly shortened limit wrap immediately.
    assign w_per_lim  = PER_W'(BASE_PERIOD >> r_level);
    assign w_per_wrap = (r_per_cnt >= (w_per_lim - PER_W'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_state_change) begin
            r_per_cnt <= '0;
        end else if (r_state == ST_PLAY) begin
            r_per_cnt <= w_per_wrap ? '0 : r_per_cnt + PER_W'(1);
        end
    end

    // Round datapath. Everything that happens on a state entry is keyed off
    // w_next_state; round_score/level only update while staying in PLAY, so
    // the value seen on OVER entry is the frozen one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_time_left   <= '0;
            r_base        <= '0;
            r_round_score <= '0;
            r_high_score  <= '0;
            r_level       <= '0;
            r_mole_load   <= 1'b0;
        end else begin
            r_mole_load <= 1'b0;
            if (w_state_change) begin
                case (w_next_state)
                    ST_COUNTDOWN: begin
                        r_time_left   <= TIME_W'(COUNTDOWN_SECS);
                        r_round_score <= '0;
                        r_level       <= '0;
                    end
                    ST_PLAY: begin
                        r_time_left <= TIME_W'(ROUND_SECS);
                        r_base      <= i_score;
                        r_mole_load <= 1'b1;
                    end
                    ST_OVER: begin
                        r_time_left <= '0;
                        if (r_round_score > r_high_score) begin
                            r_high_score <= r_round_score;
                        end
                    end
                    default: ;
                endcase
            end else begin
                if (w_sec_tick) begin
                    r_time_left <= r_time_left - TIME_W'(1);
                end
                if (r_state == ST_PLAY) begin
                    r_round_score <= w_round_next;
                    r_level       <= w_level_next;
                    r_mole_load   <= w_per_wrap;
                end
            end
        end
    end

    assign o_mole_load   = r_mole_load;
    assign o_time_left   = r_time_left;
    assign o_level       = r_level;
    assign o_round_score = r_round_score;
    assign o_high_score  = r_high_score;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl with short timing parameters.
module tb_whack_game_ctrl;
    import whack_pkg::*;

    localparam int SEC_CYCLES     = 10;
    localparam int COUNTDOWN_SECS = 2;
    localparam int ROUND_SECS     = 3;
    localparam int BASE_PERIOD    = 8;
    localparam int LEVEL_SHIFT    = 2;
    localparam int MAX_LEVEL      = 2;
    localparam int CD_LEN         = COUNTDOWN_SECS * SEC_CYCLES;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [23:0]  score = '0;
    logic         mole_rst;
    logic         mole_load;
    logic [1:0]   state;
    logic [7:0]   time_left;
    logic [2:0]   level;
    logic [23:0]  round_score;
    logic [23:0]  high_score;

    always #5 clk = ~clk;

    whack_game_ctrl #(
        .SEC_CYCLES     (SEC_CYCLES),
        .COUNTDOWN_SECS (COUNTDOWN_SECS),
        .ROUND_SECS     (ROUND_SECS),
        .BASE_PERIOD    (BASE_PERIOD),
        .LEVEL_SHIFT    (LEVEL_SHIFT),
        .MAX_LEVEL      (MAX_LEVEL)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_score       (score),
        .o_mole_rst    (mole_rst),
        .o_mole_load   (mole_load),
        .o_state       (state),
        .o_time_left   (time_left),
        .o_level       (level),
        .o_round_score (round_score),
        .o_high_score  (high_score)
    );

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        sb_on = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          cyc;
        logic        start_in;
        logic [23:0] score_in;
        logic [1:0]  st;
        logic [7:0]  tl;
        logic        ml;
        logic        mr;
        logic [23:0] rs;
        logic [2:0]  lv;
        logic [23:0] hs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int c, input logic s_in, input int sc_in,
                                input state_t st, input int tl, input logic ml,
                                input logic mr, input int rs, input int lv, input int hs);
        vec_t v;
        v.cyc = c; v.start_in = s_in; v.score_in = 24'(sc_in);
        v.st = st; v.tl = 8'(tl); v.ml = ml; v.mr = mr;
        v.rs = 24'(rs); v.lv = 3'(lv); v.hs = 24'(hs);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        run_to(v.cyc);
        chk("state",       32'(state),       32'(v.st));
        chk("time_left",   32'(time_left),   32'(v.tl));
        chk("mole_load",   32'(mole_load),   32'(v.ml));
        chk("mole_rst",    32'(mole_rst),    32'(v.mr));
        chk("round_score", 32'(round_score), 32'(v.rs));
        chk("level",       32'(level),       32'(v.lv));
        chk("high_score",  32'(high_score),  32'(v.hs));
        start = v.start_in;
        score = v.score_in;
    endtask

    // One complete round: base snapshot, +2 checkpoint, optional start poke
    // and below-base drop, final delta, and a late score change that must
    // not be counted.
    task automatic play_round(input int base, input int delta, input bit poke_start,
                              input bit drop, input int exp_high);
        int s;
        int p;
        int exp_lv;
        exp_lv = ((delta >> LEVEL_SHIFT) > MAX_LEVEL) ? MAX_LEVEL : (delta >> LEVEL_SHIFT);
        score = 24'(base);
        s = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rnd_cd_entry", 32'(state), 32'(ST_COUNTDOWN));
        p = s + 1 + CD_LEN;
        run_to(p);
        chk("rnd_play_entry", 32'(state), 32'(ST_PLAY));
        chk("rnd_play_time", 32'(time_left), 32'(ROUND_SECS));
        run_to(p + 3);
        score = 24'(base + 2);
        run_to(p + 5);
        chk("rnd_score2", 32'(round_score), 32'd2);
        if (poke_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("start_in_play_state", 32'(state), 32'(ST_PLAY));
            chk("start_in_play_time", 32'(time_left), 32'(ROUND_SECS));
        end
        if (drop) begin
            run_to(p + 6);
            score = 24'(base - 10);
            run_to(p + 8);
            chk("below_base_round", 32'(round_score), 32'd0);
            chk("below_base_level", 32'(level), 32'd0);
        end
        run_to(p + 10);
        score = 24'(base + delta);
        run_to(p + 29);
        score = 24'(base + delta + 100);
        chk("rnd_last_play", 32'(state), 32'(ST_PLAY));
        chk("rnd_last_score", 32'(round_score), 32'(delta));
        step();
        chk("rnd_over_state", 32'(state), 32'(ST_OVER));
        chk("rnd_over_time", 32'(time_left), 32'd0);
        chk("rnd_over_mole_rst", 32'(mole_rst), 32'd1);
        chk("rnd_over_round", 32'(round_score), 32'(delta));
        chk("rnd_over_level", 32'(level), 32'(exp_lv));
        chk("rnd_over_high", 32'(high_score), 32'(exp_high));
    endtask

    // ---------------- scoreboard: mole_load pulse cycles ----------------
    always @(negedge clk) begin
        if (sb_on && mole_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mole_load_extra: pulse at cycle %0d, none expected", cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (e != 32'(cyc)) begin
                    errors++;
                    $display("FAIL mole_load_time: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int p;

        // Reset values while reset is held.
        step();
        step();
        chk("rst_state",     32'(state),       32'(ST_IDLE));
        chk("rst_mole_rst",  32'(mole_rst),    32'd1);
        chk("rst_mole_load", 32'(mole_load),   32'd0);
        chk("rst_time_left", 32'(time_left),   32'd0);
        chk("rst_level",     32'(level),       32'd0);
        chk("rst_round",     32'(round_score), 32'd0);
        chk("rst_high",      32'(high_score),  32'd0);
        rst = 1'b0;
        cyc = 0;

        // Round 1 (score 0) then round 2 (base 100, level ramp to cap).
        vecs.push_back(mk(  0, 0,   0, ST_IDLE,      0, 0, 1,  0, 0,  0));
        vecs.push_back(mk(  5, 1,   0, ST_IDLE,      0, 0, 1,  0, 0,  0));
        vecs.push_back(mk(  6, 0,   0, ST_COUNTDOWN, 2, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 15, 0,   0, ST_COUNTDOWN, 2, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 16, 0,   0, ST_COUNTDOWN, 1, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 25, 0,   0, ST_COUNTDOWN, 1, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 26, 0,   0, ST_PLAY,      3, 1, 0,  0, 0,  0));
        vecs.push_back(mk( 27, 0,   0, ST_PLAY,      3, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 33, 0,   0, ST_PLAY,      3, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 34, 0,   0, ST_PLAY,      3, 1, 0,  0, 0,  0));
        vecs.push_back(mk( 35, 0,   0, ST_PLAY,      3, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 36, 0,   0, ST_PLAY,      2, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 42, 0,   0, ST_PLAY,      2, 1, 0,  0, 0,  0));
        vecs.push_back(mk( 46, 0,   0, ST_PLAY,      1, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 50, 0,   0, ST_PLAY,      1, 1, 0,  0, 0,  0));
        vecs.push_back(mk( 55, 0,   0, ST_PLAY,      1, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 56, 1, 100, ST_OVER,      0, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 57, 0, 100, ST_COUNTDOWN, 2, 0, 1,  0, 0,  0));
        vecs.push_back(mk( 77, 0, 100, ST_PLAY,      3, 1, 0,  0, 0,  0));
        vecs.push_back(mk( 79, 0, 107, ST_PLAY,      3, 0, 0,  0, 0,  0));
        vecs.push_back(mk( 80, 0, 107, ST_PLAY,      3, 0, 0,  7, 1,  0));
        vecs.push_back(mk( 81, 0, 107, ST_PLAY,      3, 1, 0,  7, 1,  0));
        vecs.push_back(mk( 85, 0, 108, ST_PLAY,      3, 1, 0,  7, 1,  0));
        vecs.push_back(mk( 86, 0, 108, ST_PLAY,      3, 0, 0,  8, 2,  0));
        vecs.push_back(mk( 87, 0, 108, ST_PLAY,      2, 1, 0,  8, 2,  0));
        vecs.push_back(mk( 88, 0, 108, ST_PLAY,      2, 0, 0,  8, 2,  0));
        vecs.push_back(mk( 91, 0, 140, ST_PLAY,      2, 1, 0,  8, 2,  0));
        vecs.push_back(mk( 92, 0, 140, ST_PLAY,      2, 0, 0, 40, 2,  0));
        vecs.push_back(mk( 97, 0, 140, ST_PLAY,      1, 1, 0, 40, 2,  0));
        vecs.push_back(mk(106, 0, 140, ST_PLAY,      1, 0, 0, 40, 2,  0));
        vecs.push_back(mk(107, 0, 140, ST_OVER,      0, 0, 1, 40, 2, 40));

        // Expected mole_load cycles for those two rounds. Round 2: period 8,
        // then 4 from cycle 80, then 2 from cycle 86; the wrap coinciding
        // with the final tick at 106 must not pulse.
        exp_q.push_back(32'd26);
        exp_q.push_back(32'd34);
        exp_q.push_back(32'd42);
        exp_q.push_back(32'd50);
        exp_q.push_back(32'd77);
        exp_q.push_back(32'd81);
        exp_q.push_back(32'd85);
        for (int c = 87; c <= 105; c += 2) exp_q.push_back(32'(c));
        sb_on = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

        run_to(110);
        sb_on = 1'b0;
        chk("mole_load_all_seen", 32'(exp_q.size()), 32'd0);

        // Reset mid-PLAY with start held high across it.
        score = 24'd500;
        s = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        p = s + 1 + CD_LEN;
        run_to(p + 3);
        score = 24'd503;
        run_to(p + 14);
        chk("pre_rst_round", 32'(round_score), 32'd3);
        rst = 1'b1;
        start = 1'b1;
        step();
        chk("midrst_state",     32'(state),       32'(ST_IDLE));
        chk("midrst_mole_rst",  32'(mole_rst),    32'd1);
        chk("midrst_mole_load", 32'(mole_load),   32'd0);
        chk("midrst_time_left", 32'(time_left),   32'd0);
        chk("midrst_high",      32'(high_score),  32'd0);
        chk("midrst_round",     32'(round_score), 32'd0);
        rst = 1'b0;
        repeat (5) step();
        chk("held_start_no_game", 32'(state), 32'(ST_IDLE));
        start = 1'b0;
        step();

        // High score across rounds: 5 -> 5, 3 -> stays 5, 9 -> 9.
        play_round(200, 5, 1'b1, 1'b0, 5);
        play_round(300, 3, 1'b0, 1'b1, 5);
        play_round(400, 9, 1'b0, 1'b0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
